// File: rtl/lc4_divider_seq.sv
// Sequential 16-bit unsigned restoring divider: one quotient bit per cycle,
// 16 RUN cycles, one-cycle DONE pulse. Divide-by-zero returns q=0, r=0.
module lc4_divider_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [15:0] i_dividend,
    input  logic [15:0] i_divisor,
    output logic        o_busy,
    output logic        o_valid,
    output logic [15:0] o_quotient,
    output logic [15:0] o_remainder
);

    localparam int unsigned W    = 16;
    localparam int unsigned CW   = 4;
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    dvd_q, dvd_d;
    logic [W-1:0]    dvs_q, dvs_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [W-1:0]    quot_out_q, quot_out_d;
    logic [W-1:0]    rem_out_q, rem_out_d;

    logic [W:0]      trial;
    logic            qbit;
    logic [W-1:0]    rem_nx;
    logic [W-1:0]    quo_nx;
    logic            accept;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_RUN;
            S_RUN:   if (cnt_q == LAST_ITER) state_d = S_DONE;
            S_DONE:  state_d = i_start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state
    always_comb begin
        o_busy      = (state_q == S_RUN);
        o_valid     = (state_q == S_DONE);
        o_quotient  = quot_out_q;
        o_remainder = rem_out_q;
    end

    // One restoring step; the compare is 17 bits wide so large divisors work,
    // while the low 16 bits of the difference are always the exact remainder.
    always_comb begin
        trial  = {rem_q, dvd_q[W-1]};
        qbit   = (trial >= {1'b0, dvs_q});
        rem_nx = qbit ? W'(trial[W-1:0] - dvs_q) : trial[W-1:0];
        quo_nx = {quo_q[W-2:0], qbit};
    end

    // Datapath next values
    always_comb begin
        accept     = i_start && (state_q != S_RUN);
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        quot_out_d = quot_out_q;
        rem_out_d  = rem_out_q;
        if (accept) begin
            dvd_d = i_dividend;
            dvs_d = i_divisor;
            rem_d = '0;
            quo_d = '0;
            cnt_d = '0;
        end else if (state_q == S_RUN) begin
            dvd_d = {dvd_q[W-2:0], 1'b0};
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = CW'(cnt_q + CW'(1));
            if (cnt_q == LAST_ITER) begin
                quot_out_d = (dvs_q == '0) ? '0 : quo_nx;
                rem_out_d  = (dvs_q == '0) ? '0 : rem_nx;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            quot_out_q <= quot_out_d;
            rem_out_q  <= rem_out_d;
        end
    end

endmodule
